// File: rtl/isram_responder.sv
// Instruction SRAM responder: answers single-word fetch requests from a
// preloadable 64-bit memory after a fixed (or optionally jittered) latency.
// Optional feature macro: ISRAM_RANDOM_DELAY_EN adds 0..3 pseudo-random extra
// wait cycles per request, drawn from an 8-bit LFSR.
module isram_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [63:0]              addr_i,
    output logic [63:0]              rdata_o,
    output logic                     done_o,
    output logic                     err_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [63:0]              wr_data_i
);

    localparam int AW = $clog2(DEPTH);
`ifdef ISRAM_RANDOM_DELAY_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cntLoad;
    logic [63:0]     addr_q;
    logic [63:0]     rdata_q;
    logic            done_q;
    logic            err_q;

    logic [63:0]     mem [DEPTH];

    logic [63:0]     offset;
    logic [63:0]     idxFull;
    logic            err_d;
    logic [63:0]     rdata_d;

`ifdef ISRAM_RANDOM_DELAY_EN
    logic [7:0]      lfsr_q;
    logic            lfsrFb;

    assign lfsrFb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign cntLoad = CW'(LATENCY - 1) + {{(CW-2){1'b0}}, lfsr_q[1:0]};

    // Free-running Fibonacci LFSR (taps 8,6,5,4) supplying the extra delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsrFb};
        end
    end
`else
    assign cntLoad = CW'(LATENCY - 1);
`endif

    // Word lookup for the latched address; any fault forces zero data.
    always_comb begin
        offset  = addr_q - BASE_ADDR;
        idxFull = offset >> 3;
        err_d   = (addr_q[2:0] != 3'b000) || (addr_q < BASE_ADDR) ||
                  (idxFull >= 64'(DEPTH));
        rdata_d = err_d ? 64'd0 : mem[idxFull[AW-1:0]];
    end

    // Backdoor preload port; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
    end

    // Request FSM: accept, count down the latency, pulse done, then hold the
    // response until the initiator releases the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 64'd0;
            rdata_q <= 64'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        cnt_q   <= cntLoad;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                        done_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!req_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_isram_responder.sv
// Self-checking bench for isram_responder: random fetches against a simple
// reference memory, with a scoreboard queue drained by an output monitor.
// Honours ISRAM_RANDOM_DELAY_EN when the bundle is built with it.
module tb_isram_responder;

    localparam int          DEPTH = 16;
    localparam int          LAT   = 2;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic        done;
    logic        err;
    logic        wrEn;
    logic [3:0]  wrIdx;
    logic [63:0] wrData;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int latHist [4];

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          c0;
    } exp_t;

    exp_t        sbq [$];
    logic [63:0] modelMem [DEPTH];

    isram_responder #(
        .DEPTH(DEPTH),
        .LATENCY(LAT),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req),
        .addr_i(addr),
        .rdata_o(rdata),
        .done_o(done),
        .err_o(err),
        .wr_en_i(wrEn),
        .wr_idx_i(wrIdx),
        .wr_data_i(wrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure accept-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: an aligned address inside [BASE, BASE+8*DEPTH) hits memory.
    function automatic void expectWord(input logic [63:0] a, output logic [63:0] d, output logic e);
        if (a[2:0] != 3'b000 || a < BASE || a >= BASE + 64'(8 * DEPTH)) begin
            e = 1'b1;
            d = 64'd0;
        end else begin
            e = 1'b0;
            d = modelMem[int'((a - BASE) / 8)];
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_done: got done=1 expected no pending request");
            end else begin
                exp_t e;
                int   lat;
                e   = sbq.pop_front();
                lat = cyc - e.c0;
                checkOutput("rdata", rdata, e.data);
                checkOutput("err", 64'(err), 64'(e.err));
`ifdef ISRAM_RANDOM_DELAY_EN
                checkOutput("latency_in_range", 64'(lat >= LAT && lat <= LAT + 3), 64'd1);
                if (lat >= LAT && lat <= LAT + 3) latHist[lat - LAT]++;
`else
                checkOutput("latency", 64'(lat), 64'(LAT));
`endif
            end
        end
    end

    task automatic writeWord(input int idx, input logic [63:0] data);
        @(negedge clk);
        wrEn   = 1'b1;
        wrIdx  = 4'(idx);
        wrData = data;
        @(posedge clk);
        #1;
        wrEn          = 1'b0;
        modelMem[idx] = data;
    endtask

    // One full fetch: raise request, wait for done, hold, then release.
    task automatic applyStimulus(input logic [63:0] a, input int hold);
        logic [63:0] d;
        logic        e;
        bit          got;
        @(negedge clk);
        req  = 1'b1;
        addr = a;
        expectWord(a, d, e);
        sbq.push_back('{data: d, err: e, c0: cyc + 1});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done for addr %h expected one within 40 cycles", a);
            void'(sbq.pop_front());
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                checkOutput("hold_done_low", 64'(done), 64'd0);
                checkOutput("hold_rdata", rdata, d);
            end
        end
        @(negedge clk);
        req  = 1'b0;
        addr = {$urandom, $urandom};
        @(posedge clk);
    endtask

    function automatic logic [63:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3, 4, 5: return BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
            6:                return BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 7));
            7:                return BASE - 64'(8 * $urandom_range(1, 100));
            8:                return BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 100));
            default:          return {$urandom, $urandom};
        endcase
    endfunction

    // Watchdog against a hung run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected completion before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nRand;
        rst    = 1'b1;
        req    = 1'b0;
        addr   = 64'd0;
        wrEn   = 1'b0;
        wrIdx  = 4'd0;
        wrData = 64'd0;
        for (int i = 0; i < 4; i++) latHist[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdata", rdata, 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        writeWord(0, 64'h0000_0013_0000_0513);
        writeWord(1, 64'h1111_2222_3333_4444);
        for (int i = 2; i < DEPTH; i++) writeWord(i, {$urandom, $urandom});

        $display("[TB] basic aligned read");
        applyStimulus(BASE, 1);

        $display("[TB] fault cases");
        applyStimulus(BASE + 64'd4, 1);
        applyStimulus(64'h7FFF_FFF8, 1);
        applyStimulus(BASE + 64'(8 * DEPTH), 1);
        applyStimulus(BASE + 64'(8 * (DEPTH - 1)), 1);

        $display("[TB] long hold then re-request");
        applyStimulus(BASE, 10);
        applyStimulus(BASE + 64'd8, 1);

        $display("[TB] abort in wait");
        @(negedge clk);
        req  = 1'b1;
        addr = BASE;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(posedge clk);

        $display("[TB] asynchronous reset in wait");
        @(negedge clk);
        req  = 1'b1;
        addr = BASE + 64'd8;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_rdata", rdata, 64'd0);
        checkOutput("async_rst_done", 64'(done), 64'd0);
        checkOutput("async_rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        repeat (6) @(posedge clk);
        applyStimulus(BASE, 1);
        applyStimulus(BASE + 64'd8, 1);

`ifndef ISRAM_RANDOM_DELAY_EN
        $display("[TB] write collides with read edge");
        @(negedge clk);
        req  = 1'b1;
        addr = BASE;
        sbq.push_back('{data: modelMem[0], err: 1'b0, c0: cyc + 1});
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        wrEn   = 1'b1;
        wrIdx  = 4'd0;
        wrData = 64'hDEAD;
        @(posedge clk);
        #1;
        wrEn        = 1'b0;
        modelMem[0] = 64'hDEAD;
        checkOutput("collide_done", 64'(done), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        applyStimulus(BASE, 1);
        nRand = 40;
`else
        nRand = 256;
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < nRand; n++) begin
            if ($urandom_range(0, 3) == 0) writeWord($urandom_range(0, DEPTH - 1), {$urandom, $urandom});
            applyStimulus(randAddr(), $urandom_range(1, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
`ifdef ISRAM_RANDOM_DELAY_EN
        for (int i = 0; i < 4; i++) checkOutput($sformatf("delay_%0d_seen", i), 64'(latHist[i] > 0), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
